// File: rtl/sipo_rx_ctrl_if.sv
// rtl/sipo_rx_ctrl_if.sv - serial-in/parallel-out frame controller bus interface
interface sipo_rx_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             din;
  logic             din_valid;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  // bit source / word consumer side
  modport master (
    output start, din, din_valid, clr_err, out_ready,
    input  data_out, out_valid, busy, overrun
  );

  // frame controller side
  modport slave (
    input  start, din, din_valid, clr_err, out_ready,
    output data_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/sipo_rx_ctrl.sv
// rtl/sipo_rx_ctrl.sv - serial-in/parallel-out frame controller with output buffering and overrun detect
module sipo_rx_ctrl #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  sipo_rx_ctrl_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] word_in;
  logic             ovr_set;

  // candidate shift-register value if this cycle's bit is accepted
  assign word_in = {sr_q[WIDTH-2:0], bus.din};

  // next-state: framing FSM, output register and sticky overrun
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;

    // a consumed word frees the output unless a new one loads below
    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      ST_SHIFT: begin
        if (bus.start) begin
          // restart discards the partial frame and this cycle's bit
          cnt_d = '0;
          sr_d  = '0;
        end else if (bus.din_valid) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (!valid_q || bus.out_ready) begin
              data_d  = word_in;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              // output still occupied: park the word in the shift register
              sr_d    = word_in;
              state_d = ST_HOLD;
            end
          end else begin
            sr_d  = word_in;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        // no room to shift while a word is parked, so any bit is lost
        if (bus.din_valid) begin
          ovr_set = 1'b1;
        end
        if (bus.out_ready) begin
          data_d  = sr_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (bus.clr_err) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.overrun   = ovr_q;

endmodule

// File: doc/sipo_rx_ctrl.md
# sipo_rx_ctrl

Frame controller for the serial-in/parallel-out datapath. It sequences serial bits into a WIDTH-bit shift register under a start/strobe protocol and counts bits to frame completion. Each completed word is presented on a registered parallel output with a valid/ready handshake. It sits between a serial bit source and a parallel consumer, and adds buffering, backpressure and overrun detection that the bare SIPO shift chain lacks.

## Interface
- WIDTH, 4, word length in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  begin a new frame (pulse)
- din  input  1  serial data bit
- din_valid  input  1  din is valid this cycle (bit strobe)
- clr_err  input  1  clears sticky overrun
- data_out  output  WIDTH  completed parallel word (registered)
- out_valid  output  1  data_out holds an unconsumed word
- out_ready  input  1  consumer accepts data_out when out_valid=1
- busy  output  1  state != IDLE
- overrun  output  1  sticky: bit strobe dropped while in HOLD

## Operation
- Internal state: shift register sr[WIDTH-1:0], bit counter cnt (clog2(WIDTH) bits), FSM {IDLE, SHIFT, HOLD}.
- Shift rule: on an accepted bit, sr <= {sr[WIDTH-2:0], din}, cnt <= cnt+1. The first bit of a frame ends in data_out[WIDTH-1]; the last bit ends in data_out[0].
- IDLE: din_valid ignored. start=1 → SHIFT with cnt=0 and sr=0.
- SHIFT:
  - start=1 aborts and restarts the frame: cnt=0, sr=0. That cycle's din_valid bit is discarded. start has priority over din_valid.
  - din_valid=1 with cnt<WIDTH-1: shift the bit in and increment cnt.
  - din_valid=1 with cnt==WIDTH-1: the frame completes. The word is w = {sr[WIDTH-2:0], din}.
    - If out_valid==0, or out_ready==1 in this cycle: data_out <= w, out_valid <= 1, state → IDLE.
    - Otherwise: sr <= w, state → HOLD.
- HOLD:
  - When out_ready==1 (out_valid is 1 here): data_out <= sr, out_valid stays 1, state → IDLE.
  - din_valid=1 in any HOLD cycle, including the release cycle, drops the bit and sets overrun.
  - start is ignored in HOLD.
- Output handshake: a word transfers on any edge with out_valid&&out_ready. out_valid clears on that edge unless a new word loads on the same edge; in that case it stays 1 and data_out takes the new word. data_out is stable while out_valid=1 and out_ready=0.
- overrun: set as above. Cleared by clr_err=1; set has priority over clear when both occur in the same cycle. Also cleared by rst.
- cnt never exceeds WIDTH-1. It wraps to 0 on completion and on restart.

## Timing
- Reset (synchronous, rst=1 at the edge): state=IDLE, sr=0, cnt=0, data_out=0, out_valid=0, busy=0, overrun=0. Reset mid-frame or in HOLD discards all partial or held data.
- Latency: start edge → busy=1 in the next cycle.
- Latency: the edge sampling the WIDTH-th bit → out_valid=1 and data_out valid in the next cycle (1 cycle), with no HOLD.
- Back-to-back frames: start can be asserted in the first cycle after completion (IDLE). The minimum frame period is WIDTH+1 cycles.
- din_valid gaps within SHIFT are allowed and unbounded. The state holds, and cnt and sr are unchanged.
- HOLD release: out_ready edge → data_out=held word and busy=0 in the next cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, start, then bits 1,0,1,1 on consecutive cycles with out_ready=0 → next cycle data_out=4'b1011, out_valid=1, busy=0. out_ready=1 for one cycle → out_valid=0.
- Same frame with din_valid gaps of 0-3 random cycles between bits → identical data_out=4'b1011, out_valid rising one cycle after the last bit.
- Backpressure:
  - First frame 1100 left unconsumed; second frame 0110 completes → busy stays 1 (HOLD), data_out=4'b1100.
  - Two din_valid pulses during HOLD → overrun=1.
  - out_ready=1 → data_out=4'b0110, busy=0.
  - clr_err → overrun=0.
- Simultaneous consume and load: out_valid=1 with 1100, out_ready=1 on the same edge as the last bit of 0011 → out_valid stays 1, data_out=4'b0011, no HOLD entered.
- Restart: start, bits 1,1, start again, bits 0,0,0,1 → data_out=4'b0001.
- Reset mid-frame: after 2 bits, assert rst → all outputs 0. A new frame 1010 → data_out=4'b1010.
